// File: rtl/counter_41.sv
// Free-running WIDTH-bit binary up-counter with synchronous active-high reset
// and a terminal-count decode for cascading.
module counter_41 #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Count register; reset wins over the increment, including at the wrap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RST_VAL;
    end else begin
      count <= count + ONE;
    end
  end

  // Terminal count looks only at the register, so it holds through a pending reset.
  assign tc = &count;

endmodule

// File: tb/tb_counter_41.sv
// Directed self-checking bench for counter_41 (default WIDTH=4, RESET_VALUE=0).
module tb_counter_41;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       tc;

  int vectors;
  int miscompares;
  int tc_pulses;

  counter_41 dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    tc_pulses   = 0;
    reset       = 1'b1;

    // Reset hold: five edges with reset high.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst_hold_count[%0d]", i), int'(count), 0);
      check($sformatf("rst_hold_tc[%0d]", i), int'(tc), 0);
    end

    // Free count 1..15, wrap to 0, then 1.
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("free_count[%0d]", i), int'(count), i);
      check($sformatf("free_tc[%0d]", i), int'(tc), (i == 15) ? 1 : 0);
    end
    step();
    check("wrap_count", int'(count), 0);
    check("wrap_tc", int'(tc), 0);
    step();
    check("post_wrap_count", int'(count), 1);

    // Long run: 25 edges from 0 gives 9 with exactly one tc pulse.
    reset = 1'b1;
    step();
    check("long_start_count", int'(count), 0);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (tc === 1'b1) tc_pulses++;
    end
    check("long_count", int'(count), 9);
    check("long_tc_pulses", tc_pulses, 1);

    // Mid-count reset at 9, then resume 1,2,3.
    reset = 1'b1;
    step();
    check("mid_rst_count", int'(count), 0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("mid_resume[%0d]", i), int'(count), i);
    end

    // Reset at terminal count: run 3 -> 15, tc stays high with reset pending.
    for (int i = 0; i < 12; i++) step();
    check("tc_reach_count", int'(count), 15);
    reset = 1'b1;
    #1;
    check("tc_held_during_reset", int'(tc), 1);
    step();
    check("tc_rst_count", int'(count), 0);
    check("tc_rst_tc", int'(tc), 0);
    reset = 1'b0;
    step();
    check("tc_rst_resume", int'(count), 1);

    // Glitch immunity: reset pulse entirely between edges is ignored.
    step();
    check("glitch_pre", int'(count), 2);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    step();
    check("glitch_post", int'(count), 3);
    step();
    check("glitch_post2", int'(count), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
